// File: rtl/ps2_scancode_sequencer_if.sv
// rtl/ps2_scancode_sequencer_if.sv - byte-in / key-event-out bundle for ps2_scancode_sequencer
//   rx_valid/rx_byte/rx_error : receiver strobe, data byte, frame/parity error
//   evt_valid/evt_ready       : show-ahead event handshake, pop on valid && ready
//   evt_code/evt_ext/evt_break: head event fields
//   fifo_count/overflow       : stored events, sticky drop flag
//   timeout_pulse             : prefix sequence abandoned
interface ps2_scancode_sequencer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_error;
  logic          evt_valid;
  logic          evt_ready;
  logic [7:0]    evt_code;
  logic          evt_ext;
  logic          evt_break;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          timeout_pulse;

  modport master (
    output rx_valid, rx_byte, rx_error, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_break, fifo_count, overflow, timeout_pulse
  );

  modport slave (
    input  rx_valid, rx_byte, rx_error, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_break, fifo_count, overflow, timeout_pulse
  );
endinterface

// File: rtl/ps2_scancode_sequencer.sv
// rtl/ps2_scancode_sequencer.sv - PS/2 set-2 prefix sequencer with show-ahead key event FIFO
//   CLK, RST : clock, synchronous active-high reset
//   bus      : ps2_scancode_sequencer_if.slave (receiver bytes in, key events out)
module ps2_scancode_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic                    CLK,
  input  logic                    RST,
  ps2_scancode_sequencer_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Counter only needs to reach PREFIX_TIMEOUT-1.
  localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            tmo_pulse_q, tmo_pulse_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [9:0]      mem_q [FIFO_DEPTH];

  logic            is_hk;
  logic            seen_e0;
  logic            seen_f0;
  logic            push;
  logic [9:0]      push_data;
  logic            pop;
  logic            full;
  logic            wr_en;

  // Prefix decoder and timeout counter.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    tmo_pulse_d = 1'b0;
    push        = 1'b0;
    push_data   = '0;

    is_hk = (bus.rx_byte == 8'h00) || (bus.rx_byte == 8'hAA) ||
            (bus.rx_byte == 8'hEE) || (bus.rx_byte == 8'hFA) ||
            (bus.rx_byte == 8'hFC) || (bus.rx_byte == 8'hFE) ||
            (bus.rx_byte == 8'hFF);
    seen_e0 = (state_q == GOT_E0) || (state_q == GOT_E0F0);
    seen_f0 = (state_q == GOT_F0) || (state_q == GOT_E0F0);

    if (bus.rx_valid) begin
      // A byte always restarts the wait window, even when it is discarded.
      tmo_cnt_d = '0;
      if (bus.rx_error || is_hk) begin
        state_d = IDLE;
      end else if (bus.rx_byte == 8'hE0) begin
        state_d = seen_f0 ? GOT_E0F0 : GOT_E0;
      end else if (bus.rx_byte == 8'hF0) begin
        state_d = seen_e0 ? GOT_E0F0 : GOT_F0;
      end else begin
        push      = 1'b1;
        push_data = {seen_e0, seen_f0, bus.rx_byte};
        state_d   = IDLE;
      end
    end else if (state_q != IDLE) begin
      if (tmo_cnt_q == T_LAST) begin
        state_d     = IDLE;
        tmo_cnt_d   = '0;
        tmo_pulse_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Event FIFO bookkeeping; a same-cycle pop makes room for a push when full.
  always_comb begin
    pop      = (count_q != '0) && bus.evt_ready;
    full     = (count_q == FULL_COUNT);
    wr_en    = push && (!full || pop);
    ovf_d    = ovf_q | (push && full && !pop);
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(wr_en) - CW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      tmo_cnt_q   <= '0;
      tmo_pulse_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_pulse_q <= tmo_pulse_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign bus.evt_valid     = (count_q != '0);
  assign bus.fifo_count    = count_q;
  assign bus.overflow      = ovf_q;
  assign bus.timeout_pulse = tmo_pulse_q;
  assign {bus.evt_ext, bus.evt_break, bus.evt_code} =
      (count_q != '0) ? mem_q[rd_ptr_q] : 10'd0;

endmodule

// File: tb/tb_ps2_scancode_sequencer.sv
// tb/tb_ps2_scancode_sequencer.sv - directed and randomized bench for ps2_scancode_sequencer
module tb_ps2_scancode_sequencer;
  localparam int DEPTH = 8;
  localparam int PT    = 20;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #10 CLK = ~CLK;

  ps2_scancode_sequencer_if #(.FIFO_DEPTH(DEPTH)) ifc ();

  ps2_scancode_sequencer #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(PT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int pulse_cnt = 0;
  always @(negedge CLK) if (ifc.timeout_pulse === 1'b1) pulse_cnt++;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending-prefix flags, event queue, sticky overflow, timeout tally.
  logic [9:0] q[$];
  bit m_pend, m_ext, m_brk, m_ovf;
  int m_last;
  int exp_tmo = 0;

  function automatic bit hk(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA ||
           b == 8'hFC || b == 8'hFE || b == 8'hFF;
  endfunction

  task automatic m_clear_prefix();
    m_pend = 0; m_ext = 0; m_brk = 0;
  endtask

  task automatic m_reset();
    q.delete(); m_ovf = 0; m_clear_prefix();
  endtask

  // A prefix is abandoned once more than PT cycles pass with no further byte.
  task automatic settle(input int t);
    if (m_pend && (t - m_last) > PT) begin
      exp_tmo++;
      m_clear_prefix();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit err, input int t);
    settle(t);
    m_last = t;
    if (err || hk(b)) m_clear_prefix();
    else if (b == 8'hE0) begin m_ext = 1; m_pend = 1; end
    else if (b == 8'hF0) begin m_brk = 1; m_pend = 1; end
    else begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back({m_ext, m_brk, b});
      m_clear_prefix();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b, input bit err);
    @(negedge CLK);
    ifc.rx_valid = 1'b1;
    ifc.rx_byte  = b;
    ifc.rx_error = err;
    model_byte(b, err, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      ifc.rx_valid = 1'b0;
      ifc.rx_error = 1'b0;
    end
  endtask

  function automatic logic [31:0] head();
    return {22'd0, ifc.evt_ext, ifc.evt_break, ifc.evt_code};
  endfunction

  // Called right after the final byte strobe: event must be visible one cycle later.
  task automatic latency_check(input string tag);
    idle(1);
    chk({tag, "_valid"}, ifc.evt_valid, 1);
    if (q.size() != 0) chk({tag, "_head"}, head(), q[0]);
    else chk({tag, "_model_nonempty"}, q.size(), 1);
  endtask

  task automatic drain(input string tag);
    idle(1);
    ifc.evt_ready = 1'b1;
    forever begin
      chk({tag, "_valid"}, ifc.evt_valid, q.size() != 0);
      chk({tag, "_count"}, ifc.fifo_count, q.size());
      if (q.size() == 0) break;
      chk({tag, "_head"}, head(), q[0]);
      void'(q.pop_front());
      @(negedge CLK);
    end
    ifc.evt_ready = 1'b0;
    chk({tag, "_ovf"}, ifc.overflow, m_ovf);
  endtask

  initial begin
    ifc.rx_valid  = 1'b0;
    ifc.rx_byte   = 8'h00;
    ifc.rx_error  = 1'b0;
    ifc.evt_ready = 1'b0;
    m_reset();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_valid", ifc.evt_valid, 0);
    chk("rst_count", ifc.fifo_count, 0);
    chk("rst_ovf", ifc.overflow, 0);
    chk("rst_pulse", ifc.timeout_pulse, 0);
    chk("rst_fields", head(), 0);

    // Make / break / extended / extended break.
    put(8'h1C, 0);                               latency_check("make");     drain("make_d");
    put(8'hF0, 0); put(8'h1C, 0);                latency_check("break");    drain("break_d");
    put(8'hE0, 0); put(8'h75, 0);                latency_check("ext");      drain("ext_d");
    put(8'hE0, 0); put(8'hF0, 0); put(8'h75, 0); latency_check("extbrk");   drain("extbrk_d");
    put(8'hF0, 0); put(8'hE0, 0); put(8'h75, 0); latency_check("brkext");   drain("brkext_d");
    put(8'hE1, 0);                               latency_check("pause");    drain("pause_d");

    // Housekeeping and error byte cancel a pending prefix.
    put(8'hAA, 0); put(8'hE0, 0); put(8'h5A, 1); put(8'h74, 0);
    latency_check("hk_err"); drain("hk_err_d");
    put(8'hE0, 0); put(8'hFA, 0); put(8'h74, 0);
    latency_check("hk_mid"); drain("hk_mid_d");

    // Timeout: abandoned prefix, then boundary gaps PT-2, PT (byte wins), PT+1 (timeout).
    put(8'hE0, 0); idle(PT + 2);
    settle(cyc);
    chk("tmo_pulse", pulse_cnt, exp_tmo);
    chk("tmo_expected_one", exp_tmo, 1);
    put(8'h6B, 0); latency_check("tmo_after"); drain("tmo_after_d");
    put(8'hE0, 0); idle(PT - 3); put(8'h6B, 0); latency_check("tmo_early"); drain("tmo_early_d");
    put(8'hE0, 0); idle(PT - 1); put(8'h6B, 0); latency_check("tmo_edge"); drain("tmo_edge_d");
    put(8'hE0, 0); idle(PT);     put(8'h6B, 0); latency_check("tmo_late"); drain("tmo_late_d");
    idle(2);
    chk("tmo_pulse_total", pulse_cnt, exp_tmo);

    // Overflow, then push coinciding with pop while full.
    for (int i = 1; i <= DEPTH + 1; i++) put(8'(i), 0);
    idle(1);
    chk("ovf_count", ifc.fifo_count, DEPTH);
    chk("ovf_flag", ifc.overflow, 1);
    chk("ovf_model", m_ovf, 1);
    chk("full_head", head(), q[0]);
    void'(q.pop_front());
    ifc.evt_ready = 1'b1;
    ifc.rx_valid  = 1'b1;
    ifc.rx_byte   = 8'h0A;
    model_byte(8'h0A, 0, cyc);
    @(negedge CLK);
    ifc.evt_ready = 1'b0;
    ifc.rx_valid  = 1'b0;
    chk("pushpop_count", ifc.fifo_count, DEPTH);
    drain("ovf_d");

    // Reset mid-prefix with events queued.
    put(8'h11, 0); put(8'h12, 0); put(8'h13, 0); put(8'hF0, 0); idle(1);
    chk("pre_rst_count", ifc.fifo_count, 3);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    m_reset();
    chk("mid_rst_valid", ifc.evt_valid, 0);
    chk("mid_rst_count", ifc.fifo_count, 0);
    chk("mid_rst_ovf", ifc.overflow, 0);
    put(8'h1C, 0); latency_check("post_rst"); drain("post_rst_d");

    // Randomized byte stream with back-to-back strobes, boundary gaps and overflow.
    begin
      int burst = 0;
      int limit = $urandom_range(4, 12);
      for (int n = 0; n < 400; n++) begin
        int r = $urandom_range(0, 15);
        int g = $urandom_range(0, 9);
        logic [7:0] b = 8'($urandom_range(0, 255));
        bit err = 0;
        if (r <= 2) b = 8'hE0;
        else if (r <= 4) b = 8'hF0;
        else if (r == 5) b = (b[0]) ? 8'hAA : 8'hFA;
        else if (r == 6) err = 1;
        else if (r == 7) b = 8'hE1;
        put(b, err);
        if (g >= 5 && g <= 7) idle($urandom_range(1, 3));
        else if (g == 8) idle(PT - 1);
        else if (g == 9) idle(PT);
        burst++;
        if (burst >= limit) begin
          drain("rand_d");
          burst = 0;
          limit = $urandom_range(4, 12);
        end
      end
      drain("rand_final");
      idle(PT + 3);
      settle(cyc);
      idle(1);
      chk("rand_pulse_total", pulse_cnt, exp_tmo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
